// File: rtl/register_file.sv
// rtl/register_file.sv - 15-entry register file with two read, two write and one debug port
//
// Purpose: architectural register file. Registers 0x0-0xE are storage; ID 0xF
// means "no register" on every port and reads as zero. Port M has priority over
// port E when both target the same register. Optional same-cycle forwarding on
// the two main read ports; the debug port always shows stored state.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high reset
//   srcA/srcB - read register IDs (4'hF = none)
//   valA/valB - combinational read data
//   dstE/dstM - write register IDs (4'hF = none)
//   valE/valM - write data for ports E and M
//   wr_en     - writeback enable for both write ports
//   dbg_sel   - debug read register ID
//   dbg_val   - debug read data, never forwarded
//   wr_count  - count of committed register writes, wraps at 2^32

module register_file #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = '0,
  parameter bit               BYPASS   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             wr_en,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val,
  output logic [31:0]      wr_count
);

  localparam logic [3:0] NONE   = 4'hF;
  localparam int         RSP_ID = 4;

  logic [WIDTH-1:0] regs [15];
  logic [31:0]      wrCount;

  logic       writeE;
  logic       writeM;
  logic       collide;
  logic [1:0] writeCount;

  assign writeE     = wr_en && (dstE != NONE);
  assign writeM     = wr_en && (dstM != NONE);
  // Two writes to one register commit only once (M's value), so count it once.
  assign collide    = writeE && writeM && (dstE == dstM);
  assign writeCount = {1'b0, writeE} + {1'b0, writeM} - {1'b0, collide};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
      end
      wrCount <= '0;
    end else begin
      // M is written after E so that it wins on a collision.
      if (writeE) regs[dstE] <= valE;
      if (writeM) regs[dstM] <= valM;
      wrCount <= wrCount + {30'd0, writeCount};
    end
  end

  function automatic logic [WIDTH-1:0] storedVal(input logic [3:0] id);
    return (id == NONE) ? '0 : regs[id];
  endfunction

  // writeM/writeE already exclude ID 0xF, so a match implies a real register.
  function automatic logic [WIDTH-1:0] forwardVal(input logic [3:0] id);
    if (BYPASS && writeM && (id == dstM)) return valM;
    if (BYPASS && writeE && (id == dstE)) return valE;
    return storedVal(id);
  endfunction

  always_comb begin
    valA    = forwardVal(srcA);
    valB    = forwardVal(srcB);
    dbg_val = storedVal(dbg_sel);
  end

  assign wr_count = wrCount;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: the data width of each register and value port.
REQ-002 The block SHALL have parameter RSP_INIT, default 64'h0: the reset value of register 4 (%rsp).
REQ-003 The block SHALL have parameter BYPASS, default 0: 1 enables write-to-read forwarding within the same cycle.
REQ-004 The block SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port srcA  input  4  register ID for read port A; 4'hF means none.
REQ-007 The block SHALL have port srcB  input  4  register ID for read port B; 4'hF means none.
REQ-008 The block SHALL have port dstE  input  4  register ID for write port E; 4'hF means none.
REQ-009 The block SHALL have port dstM  input  4  register ID for write port M; 4'hF means none.
REQ-010 The block SHALL have port valE  input  WIDTH  write data for port E (ALU result).
REQ-011 The block SHALL have port valM  input  WIDTH  write data for port M (memory result).
REQ-012 The block SHALL have port wr_en  input  1  writeback enable; both write ports are inert when low.
REQ-013 The block SHALL have port valA  output  WIDTH  read data for srcA.
REQ-014 The block SHALL have port valB  output  WIDTH  read data for srcB.
REQ-015 The block SHALL have port dbg_sel  input  4  register ID for the debug read port.
REQ-016 The block SHALL have port dbg_val  output  WIDTH  debug read data; never bypassed.
REQ-017 The block SHALL have port wr_count  output  32  running count of register writes actually committed.

Function
REQ-018 The block SHALL hold 15 registers with IDs 0x0-0xE; ID 0xF is not storage.
REQ-019 valA, valB and dbg_val SHALL be combinational reads of the addressed register; ID 0xF SHALL read 0.
REQ-020 On the rising edge of clk with wr_en=1 and dstE!=0xF, register[dstE] SHALL load valE.
REQ-021 On the rising edge of clk with wr_en=1 and dstM!=0xF, register[dstM] SHALL load valM.
REQ-022 When dstE==dstM!=0xF with wr_en=1, port M SHALL win: the register loads valM and valE is discarded (popq %rsp semantics).
REQ-023 With BYPASS=0, a read of a register being written in the same cycle SHALL return the pre-edge value.
REQ-024 With BYPASS=1, valA/valB SHALL return valM if srcX==dstM, else valE if srcX==dstE, for a non-0xF ID with wr_en=1; otherwise the stored value.
REQ-025 wr_count SHALL increment on each clock edge by the number of distinct registers written that edge (0, 1 or 2); a dstE/dstM collision counts as 1.
REQ-026 wr_count SHALL wrap modulo 2^32 without saturation or a flag.
REQ-027 With wr_en=0, no register and no wr_count bit SHALL change, regardless of dstE/dstM.

Reset
REQ-028 Assertion of reset SHALL immediately and asynchronously clear all registers to 0, except register 4, which SHALL load RSP_INIT.
REQ-029 Assertion of reset SHALL also clear wr_count to 0.
REQ-030 While reset is high, writes SHALL be ignored; reads SHALL return the reset values.
REQ-031 Reset asserted mid-cycle SHALL take effect without waiting for clk.
REQ-032 The first write after reset deasserts SHALL occur on the first rising clk edge with reset low.

Verification
REQ-033 Reset scenario: with RSP_INIT=64'h200, pulse reset, then sweep srcA over 0-0xF -> valA=0 for all IDs except ID 4, which reads 64'h200; ID 0xF reads 0; wr_count=0.
REQ-034 Dual-write scenario: wr_en=1, dstE=2, valE=5, dstM=3, valM=9 for one edge -> reg2=5, reg3=9, wr_count=2.
REQ-035 Collision scenario: dstE=dstM=4, valE=8, valM=64'hABCD -> reg4=64'hABCD, wr_count increments by 1.
REQ-036 Read-during-write scenario: reg1=7, then dstE=1, valE=11, srcA=1 -> valA before the edge is 7 with BYPASS=0 and 11 with BYPASS=1; dbg_val=7 in both cases.
REQ-037 Enable/none scenario: either wr_en=0 with dstE=5, or wr_en=1 with dstE=dstM=0xF -> no register changes and wr_count is unchanged.
REQ-038 Async/wrap scenario: preload wr_count to 32'hFFFFFFFF, do one single write -> wr_count=0; then assert reset between clock edges -> all state resets before the next edge.
